// File: rtl/coin_acceptor.sv
// Coin-sensor front end: debounces raw sensor readings, classifies them into denomination values,
// buffers valid coins in a small FIFO and presents them to the vending FSM one pulse at a time.
module coin_acceptor #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sense_valid,
  input  logic [2:0]  sense_code,
  input  logic        accept_en,
  output logic [15:0] coin_in,
  output logic        reject_out,
  output logic        full,
  output logic [3:0]  count
);

  localparam int unsigned PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DB_LAST = 4'(DEBOUNCE);
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_CLASSIFY,
    S_WAIT_RELEASE
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [2:0]      code_q, code_d;
  logic            init_q, init_d;
  logic [15:0]     mem_q [DEPTH];
  logic [15:0]     mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [3:0]      count_q, count_d;
  logic            full_q, full_d;
  logic [15:0]     coin_q, coin_d;
  logic            reject_q, reject_d;

  logic [15:0]     coin_val;
  logic            classify;
  logic            push;
  logic            pop;

  function automatic logic [15:0] denom(input logic [2:0] c);
    logic [15:0] v;
    case (c)
      3'd1:    v = 16'd10;
      3'd2:    v = 16'd20;
      3'd3:    v = 16'd50;
      3'd4:    v = 16'd100;
      3'd5:    v = 16'd200;
      default: v = 16'd0;
    endcase
    return v;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Sensing FSM. init_q marks the first clock after reset so that a coin
  // already in the sensor at reset release is skipped rather than debounced.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    init_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sense_valid) begin
          if (init_q) begin
            state_d = S_WAIT_RELEASE;
          end else begin
            cnt_d   = 4'd1;
            code_d  = sense_code;
            state_d = (DEBOUNCE == 1) ? S_CLASSIFY : S_DEBOUNCE;
          end
        end
      end
      S_DEBOUNCE: begin
        if (!sense_valid) begin
          state_d = S_IDLE;
        end else if (sense_code != code_q) begin
          cnt_d  = 4'd1;
          code_d = sense_code;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == DB_LAST) begin
            state_d = S_CLASSIFY;
          end
        end
      end
      S_CLASSIFY: begin
        state_d = S_WAIT_RELEASE;
      end
      S_WAIT_RELEASE: begin
        if (!sense_valid) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO and output stage. Full is judged on the registered count, so a coin
  // classified while full is rejected even if a pop happens in the same cycle.
  always_comb begin
    coin_val = denom(code_q);
    classify = (state_q == S_CLASSIFY);
    push     = classify && (coin_val != '0) && !full_q;
    reject_d = classify && ((coin_val == '0) || full_q);
    pop      = (count_q != '0) && accept_en && (coin_q == '0);

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = coin_val;
    end
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    coin_d   = pop  ? mem_q[rd_ptr_q]   : '0;

    case ({push, pop})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
    full_d = (count_d == DEPTH_C);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      code_q   <= '0;
      init_q   <= 1'b1;
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      coin_q   <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      init_q   <= init_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      coin_q   <= coin_d;
      reject_q <= reject_d;
    end
  end

  assign coin_in    = coin_q;
  assign reject_out = reject_q;
  assign full       = full_q;
  assign count      = count_q;

endmodule
